// File: rtl/iniciador_pkg.sv
// iniciador_pkg: shared state encoding and default sizing for the INIT/DONE master sequencer.
package iniciador_pkg;
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 1023;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      PULSE     = 3'd2,
      WAIT_LOW  = 3'd3,
      WAIT_HIGH = 3'd4,
      CAPTURE   = 3'd5,
      TMO       = 3'd6
   } state_t;
endpackage

// File: rtl/iniciador_operacion_contador_espera.sv
// contador_espera: saturating wait counter with synchronous clear and at-limit flag.
module contador_espera #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] outc,
   input  logic [W-1:0] limit,
   output logic         at_limit
);
   assign at_limit = outc == limit;
   always_ff @(posedge clk or posedge reset)
      if (reset) outc <= '0;
      else if (clr) outc <= '0;
      else if (inc && !at_limit) outc <= outc + 1'b1;
endmodule

// File: rtl/iniciador_operacion.sv
// iniciador_operacion: master side of the INIT/DONE handshake; latches operands, pulses INIT,
// waits for a fresh DONE and returns RESULTADO with a one-cycle strobe or flags a timeout.
module iniciador_operacion
   import iniciador_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             START,
   input  logic [WIDTH-1:0] A_IN,
   input  logic [WIDTH-1:0] B_IN,
   output logic             BUSY,
   output logic [WIDTH-1:0] OP1,
   output logic [WIDTH-1:0] OP2,
   output logic             INIT,
   input  logic             DONE,
   input  logic [WIDTH-1:0] RESULTADO,
   output logic [WIDTH-1:0] RES_OUT,
   output logic             RES_VALID,
   output logic             ERR
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t          state;
   logic [CW-1:0]   cnt_unused;
   logic            expired;
   // Cleared in LOAD and counting from PULSE on, so TMO lands TIMEOUT cycles after PULSE.
   contador_espera #(.W(CW)) u_espera (
      .clk      (clk),
      .reset    (reset),
      .clr      (state == LOAD),
      .inc      (state == PULSE || state == WAIT_LOW || state == WAIT_HIGH),
      .outc     (cnt_unused),
      .limit    (CW'(TIMEOUT - 1)),
      .at_limit (expired)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= IDLE;
         BUSY      <= 1'b0;
         INIT      <= 1'b0;
         RES_VALID <= 1'b0;
         ERR       <= 1'b0;
         OP1       <= '0;
         OP2       <= '0;
         RES_OUT   <= '0;
      end else begin
         INIT      <= 1'b0;
         RES_VALID <= 1'b0;
         case (state)
            IDLE:
               if (START) begin
                  OP1   <= A_IN;
                  OP2   <= B_IN;
                  ERR   <= 1'b0;
                  BUSY  <= 1'b1;
                  state <= LOAD;
               end
            LOAD: begin
               INIT  <= 1'b1;
               state <= PULSE;
            end
            PULSE: state <= WAIT_LOW;
            WAIT_LOW:
               if (!DONE) state <= WAIT_HIGH;
               else if (expired) state <= TMO;
            // DONE takes priority over an expiry on the same edge
            WAIT_HIGH:
               if (DONE) begin
                  RES_OUT   <= RESULTADO;
                  RES_VALID <= 1'b1;
                  state     <= CAPTURE;
               end else if (expired) state <= TMO;
            CAPTURE: begin
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            TMO: begin
               ERR   <= 1'b1;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               BUSY  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_iniciador_operacion.sv
// tb_iniciador_operacion: directed checks of the INIT/DONE master against a multiplier-like responder.
module tb_iniciador_operacion;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        START = 1'b0;
   logic [15:0] A_IN = '0;
   logic [15:0] B_IN = '0;
   logic        BUSY, INIT, RES_VALID, ERR;
   logic [15:0] OP1, OP2, RES_OUT;
   logic        DONE = 1'b0;
   logic [15:0] RESULTADO = '0;
   int tests = 0;
   int fails = 0;
   int mode = 0;
   int lat = 5;
   int rcnt = 0;
   int ini_cnt = 0;
   int val_cnt = 0;

   iniciador_operacion #(.WIDTH(16), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .START(START), .A_IN(A_IN), .B_IN(B_IN),
      .BUSY(BUSY), .OP1(OP1), .OP2(OP2), .INIT(INIT), .DONE(DONE),
      .RESULTADO(RESULTADO), .RES_OUT(RES_OUT), .RES_VALID(RES_VALID), .ERR(ERR)
   );

   always #5 clk = ~clk;

   // responder: mode 0 drops DONE after INIT and raises it lat cycles later; 1 stuck high; 2 stuck low
   always @(negedge clk) begin
      if (mode == 1) DONE = 1'b1;
      else if (mode == 2) DONE = 1'b0;
      else if (INIT) begin
         DONE = 1'b0;
         rcnt = lat;
      end else if (rcnt > 0) begin
         if (rcnt == 1) begin
            DONE = 1'b1;
            RESULTADO = 16'(OP1 * OP2);
         end
         rcnt--;
      end
   end

   always @(posedge clk) begin
      if (INIT) ini_cnt++;
      if (RES_VALID) val_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      step(2);
      tests++; if ({BUSY, INIT, RES_VALID, ERR, OP1, OP2, RES_OUT} !== 52'd0) begin fails++; $display("FAIL reset_outputs got %h want 0", {BUSY, INIT, RES_VALID, ERR, OP1, OP2, RES_OUT}); end
      reset = 1'b0;
      step(2);
      tests++; if (BUSY !== 1'b0 || INIT !== 1'b0) begin fails++; $display("FAIL reset_release busy=%b init=%b want 0 0", BUSY, INIT); end
   endtask

   task automatic test_normal;
      int i0 = ini_cnt;
      int v0 = val_cnt;
      logic ok = 1'b1;
      START = 1'b1; A_IN = 16'h0012; B_IN = 16'h0034;
      step(1);
      START = 1'b0; A_IN = 16'h5555; B_IN = 16'haaaa;
      tests++; if (BUSY !== 1'b1 || INIT !== 1'b0) begin fails++; $display("FAIL normal_load busy=%b init=%b want 1 0", BUSY, INIT); end
      tests++; if (OP1 !== 16'h0012 || OP2 !== 16'h0034) begin fails++; $display("FAIL normal_ops got %h %h want 0012 0034", OP1, OP2); end
      step(1);
      tests++; if (INIT !== 1'b1) begin fails++; $display("FAIL normal_init got %b want 1", INIT); end
      for (int n = 3; n <= 7; n++) begin
         step(1);
         if (OP1 !== 16'h0012 || OP2 !== 16'h0034 || INIT !== 1'b0 || RES_VALID !== 1'b0) ok = 1'b0;
      end
      tests++; if (!ok) begin fails++; $display("FAIL normal_wait_stable got ok=%b want 1", ok); end
      step(1);
      tests++; if (RES_VALID !== 1'b1 || RES_OUT !== 16'h03A8) begin fails++; $display("FAIL normal_capture valid=%b res=%h want 1 03a8", RES_VALID, RES_OUT); end
      step(1);
      tests++; if (BUSY !== 1'b0 || ERR !== 1'b0 || RES_VALID !== 1'b0) begin fails++; $display("FAIL normal_idle busy=%b err=%b valid=%b want 0 0 0", BUSY, ERR, RES_VALID); end
      tests++; if (ini_cnt - i0 != 1 || val_cnt - v0 != 1) begin fails++; $display("FAIL normal_pulses init=%0d valid=%0d want 1 1", ini_cnt - i0, val_cnt - v0); end
   endtask

   task automatic test_stale;
      int v0;
      logic ok = 1'b1;
      mode = 1;
      step(3);
      v0 = val_cnt;
      START = 1'b1; A_IN = 16'h0001; B_IN = 16'h0002;
      step(1);
      START = 1'b0;
      step(1);
      tests++; if (INIT !== 1'b1) begin fails++; $display("FAIL stale_init got %b want 1", INIT); end
      for (int n = 3; n <= 10; n++) begin
         step(1);
         if (ERR !== 1'b0 || BUSY !== 1'b1 || RES_VALID !== 1'b0) ok = 1'b0;
      end
      tests++; if (!ok) begin fails++; $display("FAIL stale_early_err got ok=%b want 1", ok); end
      step(1);
      tests++; if (ERR !== 1'b1 || BUSY !== 1'b0) begin fails++; $display("FAIL stale_err err=%b busy=%b want 1 0", ERR, BUSY); end
      tests++; if (RES_OUT !== 16'h03A8 || val_cnt != v0) begin fails++; $display("FAIL stale_no_capture res=%h valid=%0d want 03a8 0", RES_OUT, val_cnt - v0); end
   endtask

   task automatic test_silent;
      mode = 2;
      step(2);
      START = 1'b1; A_IN = 16'h0003; B_IN = 16'h0004;
      step(1);
      START = 1'b0;
      step(9);
      tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL silent_early got %b want 0", ERR); end
      step(1);
      tests++; if (ERR !== 1'b1) begin fails++; $display("FAIL silent_err got %b want 1", ERR); end
      mode = 0; lat = 2;
      step(2);
      START = 1'b1; A_IN = 16'h0005; B_IN = 16'h0007;
      step(1);
      START = 1'b0;
      tests++; if (ERR !== 1'b0) begin fails++; $display("FAIL silent_err_clear got %b want 0", ERR); end
      step(4);
      tests++; if (RES_VALID !== 1'b1 || RES_OUT !== 16'h0023) begin fails++; $display("FAIL silent_recover valid=%b res=%h want 1 0023", RES_VALID, RES_OUT); end
      step(1);
      tests++; if (BUSY !== 1'b0 || ERR !== 1'b0) begin fails++; $display("FAIL silent_idle busy=%b err=%b want 0 0", BUSY, ERR); end
   endtask

   task automatic test_start_ignored;
      int i0;
      lat = 5;
      step(1);
      i0 = ini_cnt;
      START = 1'b1; A_IN = 16'h0002; B_IN = 16'h0003;
      step(1);
      START = 1'b0;
      step(4);
      START = 1'b1; A_IN = 16'hFFFF; B_IN = 16'hFFFF;
      step(1);
      START = 1'b0;
      tests++; if (OP1 !== 16'h0002 || OP2 !== 16'h0003) begin fails++; $display("FAIL ignore_ops got %h %h want 0002 0003", OP1, OP2); end
      step(2);
      tests++; if (RES_VALID !== 1'b1 || RES_OUT !== 16'h0006) begin fails++; $display("FAIL ignore_capture valid=%b res=%h want 1 0006", RES_VALID, RES_OUT); end
      step(4);
      tests++; if (BUSY !== 1'b0 || ini_cnt - i0 != 1 || OP1 !== 16'h0002) begin fails++; $display("FAIL ignore_no_queue busy=%b inits=%0d op1=%h want 0 1 0002", BUSY, ini_cnt - i0, OP1); end
   endtask

   task automatic test_reset_mid;
      lat = 5;
      START = 1'b1; A_IN = 16'h0010; B_IN = 16'h0010;
      step(1);
      START = 1'b0;
      step(4);
      reset = 1'b1;
      #1;
      tests++; if ({BUSY, INIT, RES_VALID, ERR, OP1, OP2, RES_OUT} !== 52'd0) begin fails++; $display("FAIL midreset_outputs got %h want 0", {BUSY, INIT, RES_VALID, ERR, OP1, OP2, RES_OUT}); end
      step(1);
      reset = 1'b0;
      step(4);
      START = 1'b1; A_IN = 16'h0100; B_IN = 16'h0003;
      step(1);
      START = 1'b0;
      step(1);
      tests++; if (INIT !== 1'b1) begin fails++; $display("FAIL midreset_init got %b want 1", INIT); end
      step(6);
      tests++; if (RES_VALID !== 1'b1 || RES_OUT !== 16'h0300) begin fails++; $display("FAIL midreset_capture valid=%b res=%h want 1 0300", RES_VALID, RES_OUT); end
      step(1);
      tests++; if (BUSY !== 1'b0 || ERR !== 1'b0) begin fails++; $display("FAIL midreset_idle busy=%b err=%b want 0 0", BUSY, ERR); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] a [4] = '{16'h0011, 16'h0100, 16'h00FF, 16'h0123};
      logic [15:0] b [4] = '{16'h0002, 16'h0100, 16'h00FF, 16'h0010};
      logic [15:0] r [4] = '{16'h0022, 16'h0000, 16'hFE01, 16'h1230};
      int v0;
      lat = 3;
      step(2);
      v0 = val_cnt;
      START = 1'b1; A_IN = a[0]; B_IN = b[0];
      for (int i = 0; i < 4; i++) begin
         step(1);
         tests++; if (BUSY !== 1'b1 || OP1 !== a[i] || OP2 !== b[i]) begin fails++; $display("FAIL b2b_accept%0d busy=%b ops=%h %h want 1 %h %h", i, BUSY, OP1, OP2, a[i], b[i]); end
         step(1);
         tests++; if (INIT !== 1'b1) begin fails++; $display("FAIL b2b_init%0d got %b want 1", i, INIT); end
         step(4);
         tests++; if (RES_VALID !== 1'b1 || RES_OUT !== r[i]) begin fails++; $display("FAIL b2b_result%0d valid=%b res=%h want 1 %h", i, RES_VALID, RES_OUT, r[i]); end
         if (i < 3) begin
            A_IN = a[i+1]; B_IN = b[i+1];
         end else START = 1'b0;
         step(1);
         tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL b2b_gap%0d busy=%b want 0", i, BUSY); end
      end
      step(3);
      tests++; if (BUSY !== 1'b0 || val_cnt - v0 != 4) begin fails++; $display("FAIL b2b_end busy=%b valids=%0d want 0 4", BUSY, val_cnt - v0); end
   endtask

   initial begin
      test_reset;
      test_normal;
      test_stale;
      test_silent;
      test_start_ignored;
      test_reset_mid;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end
endmodule

// File: doc/iniciador_operacion.md
# iniciador_operacion

Master-side sequencer for the team's INIT/DONE operation handshake. It accepts an operand pair from the user side, presents the operands to a datapath unit (multiplier, divider, square root, …), pulses INIT, and waits for that unit's DONE. It then captures RESULTADO and returns it with a one-cycle valid strobe, or flags a timeout. It sits between top-level control (buttons, UART or test sequencer) and any arithmetic block that implements the INIT/DONE responder side.

## Interface
- WIDTH, 16: operand and result width.
- TIMEOUT, 1023: maximum cycles spent waiting on the responder; minimum 2.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- A_IN  in  WIDTH  operand 1, captured when START is accepted.
- B_IN  in  WIDTH  operand 2, captured when START is accepted.
- BUSY  out  1  high whenever state ≠ IDLE.
- OP1  out  WIDTH  registered operand 1 to responder; held stable for the whole transaction.
- OP2  out  WIDTH  registered operand 2 to responder; held stable for the whole transaction.
- INIT  out  1  one-cycle start pulse to responder.
- DONE  in  1  responder completion level.
- RESULTADO  in  WIDTH  responder result; valid while DONE=1.
- RES_OUT  out  WIDTH  last captured result.
- RES_VALID  out  1  one-cycle strobe; RES_OUT is new.
- ERR  out  1  sticky timeout flag.

## Operation
- Reset (async, immediate): state=IDLE, timeout counter=0. All outputs are 0: BUSY, INIT, OP1, OP2, RES_OUT, RES_VALID, ERR.
- IDLE: if START=1 at an edge, register A_IN→OP1 and B_IN→OP2, clear ERR, go LOAD. START while not IDLE is ignored; no queuing.
- LOAD: one setup cycle with operands stable and INIT=0. Go PULSE.
- PULSE: INIT=1 for exactly this cycle. Clear counter. Go WAIT_LOW.
- WAIT_LOW: wait for DONE=0, so a stale DONE from the previous transaction is rejected. Counter increments each cycle. DONE=0 → WAIT_HIGH. Counter reaching TIMEOUT → TMO.
- WAIT_HIGH: at the first edge with DONE=1, latch RESULTADO→RES_OUT and go CAPTURE. Counter keeps counting; counter reaching TIMEOUT → TMO. If DONE=1 and the counter reaches TIMEOUT on the same edge, DONE wins.
- CAPTURE: RES_VALID=1 for this cycle. Go IDLE.
- TMO: set ERR=1. RES_OUT is unchanged and RES_VALID stays 0. Go IDLE.
- The counter is shared by both wait states. Its width is clog2(TIMEOUT+1); it saturates and never wraps.
- OP1 and OP2 change only on START acceptance or reset.

## Timing
- START accepted at edge k:
  - LOAD during cycle k+1.
  - INIT=1 during cycle k+2.
  - WAIT_LOW from cycle k+3.
- BUSY rises with LOAD.
- DONE first seen high at edge m in WAIT_HIGH: RES_OUT updates at m, RES_VALID=1 during cycle m+1, BUSY=0 from m+2. Earliest next START accept is edge m+2.
- Minimum transaction, with DONE low at k+3 and high at k+4: RES_VALID in cycle k+5.
- Timeout: TMO is entered TIMEOUT cycles after PULSE; ERR rises one cycle later.
- Reset asserted in any state aborts the transaction; INIT and RES_VALID are never left asserted.

## Structure
- Shared package `iniciador_pkg`:
  - state encoding localparams (IDLE, LOAD, PULSE, WAIT_LOW, WAIT_HIGH, CAPTURE, TMO);
  - default WIDTH and TIMEOUT constants.
- Sub-module `contador_espera` (width-parameterized), used as the timeout counter:
  - ports clk, reset (async), clr, inc, outc, limit;
  - saturates at `limit`, asserts `at_limit`.
- FSM and capture registers live in the top block.

## Test plan
- Normal: A=0x0012, B=0x0034, responder model drops DONE 1 cycle after INIT and raises it 5 cycles later with 0x03A8 → exactly one INIT pulse, OP1/OP2 stable throughout, RES_OUT=0x03A8, one RES_VALID, ERR=0.
- Stale DONE: DONE stuck high, never drops, TIMEOUT=8 → no capture, ERR=1 exactly 9 cycles after INIT, RES_VALID never asserted, RES_OUT unchanged.
- Silent responder: DONE stuck low, TIMEOUT=8 → ERR=1. A following START with a good responder clears ERR and completes normally.
- START pulses with A=0xFFFF during WAIT_HIGH → ignored; OP1 holds the first operand; only one INIT.
- Reset asserted mid-WAIT_HIGH → all outputs 0 immediately. The next START runs a clean transaction.
- Back-to-back: START held high continuously with a responder latency of 3 → a new transaction is accepted 2 cycles after each CAPTURE. Each RES_VALID carries the matching result, over 4 consecutive operations.
